imem_responder: RTL
===================

// Module: imem_responder
// PURPOSE
//   Memory-side responder for the core's instruction-fetch request path: accepts word-address
//   fetch requests and returns the instruction word after a fixed latency, in order.
//   Supports several outstanding requests, a flush that drops in-flight responses, and a
//   write port for preloading and self-modifying code.
//   Sits between the cpu top-level fetch port (adr/resp_data) and the program memory.
// PARAMETERS
//   xlen            32     data/address width
//   DEPTH_WORDS     1024   memory size in xlen-bit words
//   BASE_ADR        0      byte address of word 0
//   LATENCY         2      accept-to-earliest-response cycles (>=1)
//   MAX_OUTSTANDING 4      max requests in flight (pipeline + response FIFO), >=1
// PORTS
//   clk        in   1            clock, all logic on rising edge
//   rst_n      in   1            asynchronous, active-low reset
//   req_valid  in   1            fetch request present
//   req_ready  out  1            responder can accept a request
//   req_adr    in   xlen         byte address of requested word
//   resp_valid out  1            response word available
//   resp_ready in   1            consumer takes response
//   resp_data  out  xlen         returned word (0 when resp_err)
//   resp_err   out  1            misaligned or out-of-range request
//   flush      in   1            discard all in-flight/queued responses
//   wr_en      in   1            memory write strobe
//   wr_adr     in   xlen         byte address of write (word-aligned)
//   wr_data    in   xlen         write data
// BEHAVIOUR
// - Reset (rst_n low, async): outstanding=0, pipeline and FIFO empty; resp_valid=0,
//   resp_data=0, resp_err=0, req_ready=0 while in reset. Memory contents not reset.
// - req_ready = !flush && (outstanding < MAX_OUTSTANDING). Accept = req_valid && req_ready.
// - On accept: idx = (req_adr - BASE_ADR) >> 2; err = req_adr[1:0]!=0 || req_adr<BASE_ADR ||
//   idx>=DEPTH_WORDS. Data read from memory in the accept cycle (read-at-accept); err forces 0.
// - {data,err} travels a LATENCY-stage shift pipeline with per-stage valid, then enters an
//   in-order response FIFO of depth MAX_OUTSTANDING. Accept in cycle N -> resp_valid
//   earliest in cycle N+LATENCY (FIFO empty). Order of responses = order of accepts.
// - resp_valid = FIFO not empty; resp_data/resp_err = FIFO head, stable while
//   resp_valid && !resp_ready. Pop on resp_valid && resp_ready.
// - outstanding: +1 on accept, -1 on pop, unchanged when both in same cycle. Limit guarantees
//   FIFO never overflows; no back-pressure into the latency pipeline is needed.
// - Write: wr_en writes wr_data at word (wr_adr-BASE_ADR)>>2 on the clock edge; ignored when
//   out of range or misaligned. Write and accept to the same word in one cycle: response
//   carries OLD data; an accept in the following cycle sees the new data.
// - flush: synchronous; in the flush cycle no accept, no pop; at the edge, pipeline valids,
//   FIFO and outstanding cleared. resp_valid=0 the cycle after; req_ready=1 the cycle after.
//   A pop presented in the flush cycle is not counted (response discarded).
// - Reset asserted mid-operation: all in-flight responses lost, state as above.
// TESTING
// - Write 0xDEADBEEF to 0x10, accept req_adr=0x10 in cycle N, resp_ready=1 -> resp_valid=1,
//   resp_data=0xDEADBEEF, resp_err=0 in cycle N+2, only one response.
// - resp_ready=0, req_valid=1 with adrs 0x0,0x4,0x8,0xC,0x10 -> 4 accepts, req_ready=0 after
//   4th; raise resp_ready -> responses for 0x0..0xC in order, then 0x10 accepted and returned.
// - req_adr=0x12 -> resp_err=1, resp_data=0; req_adr=0x1000 (DEPTH 1024) -> resp_err=1.
// - 3 outstanding, pulse flush -> no resp_valid in following cycles, req_ready=1 next cycle,
//   new request to 0x4 returns correct data with no stale response ahead of it.
// - outstanding=3 with simultaneous accept and pop -> outstanding stays 3; same-cycle write and
//   accept to 0x8 -> old data returned, next-cycle accept returns new data.
// - Assert rst_n low with 2 responses pending -> resp_valid=0 immediately, req_ready=0 during
//   reset, req_ready=1 and no stale responses after release.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder
// Memory-side responder for the instruction-fetch path. A fetch request is
// accepted when there is room for it, the word is read in the accept cycle,
// and the result travels a fixed-latency pipeline into an in-order response
// FIFO. A flush discards everything in flight. A separate write port
// preloads memory or patches code while fetches are running.
module imem_responder #(
    parameter int          xlen            = 32,
    parameter int          DEPTH_WORDS     = 1024,
    parameter int unsigned BASE_ADR        = 0,
    parameter int          LATENCY         = 2,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [xlen-1:0] req_adr,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [xlen-1:0] resp_data,
    output logic            resp_err,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [xlen-1:0] wr_adr,
    input  logic [xlen-1:0] wr_data
);

    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PIPE_N = (LATENCY > 1) ? (LATENCY - 1) : 1;
    localparam logic [xlen-1:0]  BASE_L = xlen'(BASE_ADR);
    localparam logic [xlen-1:0]  DEPTH_L = xlen'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [xlen-1:0] mem [DEPTH_WORDS];

    logic [xlen-1:0]  rd_off_s;
    logic [xlen-1:0]  rd_word_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             err_s;
    logic [xlen-1:0]  rd_data_s;
    logic [xlen-1:0]  wr_off_s;
    logic [xlen-1:0]  wr_word_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             wr_bad_s;

    logic             accept_s;
    logic             pop_s;
    logic             push_v_s;
    logic             push_e_s;
    logic [xlen-1:0]  push_d_s;

    logic [CNT_W-1:0] outstanding_r;
    logic [CNT_W-1:0] fifo_cnt_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [xlen-1:0]  fd_r [MAX_OUTSTANDING];
    logic             fe_r [MAX_OUTSTANDING];

    // Decode the fetch address and read the word in the accept cycle.
    always_comb begin
        rd_off_s  = req_adr - BASE_L;
        rd_word_s = rd_off_s >> 2;
        rd_idx_s  = rd_word_s[IDX_W-1:0];
        err_s     = (req_adr[1:0] != 2'b00) || (req_adr < BASE_L) || (rd_word_s >= DEPTH_L);
        if (err_s) begin
            rd_data_s = {xlen{1'b0}};
        end else begin
            rd_data_s = mem[rd_idx_s];
        end
    end

    // Decode the write address; bad writes are silently dropped.
    always_comb begin
        wr_off_s  = wr_adr - BASE_L;
        wr_word_s = wr_off_s >> 2;
        wr_idx_s  = wr_word_s[IDX_W-1:0];
        wr_bad_s  = (wr_adr[1:0] != 2'b00) || (wr_adr < BASE_L) || (wr_word_s >= DEPTH_L);
    end

    // Memory write port; the read above sees the old word in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_bad_s) begin
            mem[wr_idx_s] <= wr_data;
        end
    end

    assign req_ready = rst_n && !flush && (outstanding_r < MAX_L);
    assign accept_s  = req_valid && req_ready;
    assign pop_s     = resp_valid && resp_ready && !flush;

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [PIPE_N-1:0] pv_r;
            logic [PIPE_N-1:0] pe_r;
            logic [xlen-1:0]   pd_r [PIPE_N];

            // Fixed-latency shift pipeline carrying {data, err} with per-stage valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv_r <= {PIPE_N{1'b0}};
                    pe_r <= {PIPE_N{1'b0}};
                    for (int i = 0; i < PIPE_N; i++) begin
                        pd_r[i] <= {xlen{1'b0}};
                    end
                end else if (flush) begin
                    pv_r <= {PIPE_N{1'b0}};
                end else begin
                    pv_r[0] <= accept_s;
                    pe_r[0] <= err_s;
                    pd_r[0] <= rd_data_s;
                    for (int i = 1; i < PIPE_N; i++) begin
                        pv_r[i] <= pv_r[i-1];
                        pe_r[i] <= pe_r[i-1];
                        pd_r[i] <= pd_r[i-1];
                    end
                end
            end

            assign push_v_s = pv_r[PIPE_N-1];
            assign push_e_s = pe_r[PIPE_N-1];
            assign push_d_s = pd_r[PIPE_N-1];
        end else begin : g_direct
            assign push_v_s = accept_s;
            assign push_e_s = err_s;
            assign push_d_s = rd_data_s;
        end
    endgenerate

    // Response FIFO storage; never overflows because outstanding is capped.
    always_ff @(posedge clk) begin
        if (push_v_s && !flush) begin
            fd_r[wr_ptr_r] <= push_d_s;
            fe_r[wr_ptr_r] <= push_e_s;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt_r <= {CNT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
        end else if (flush) begin
            fifo_cnt_r <= {CNT_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
        end else begin
            if (push_v_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_v_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Requests accepted but not yet consumed (pipeline plus FIFO).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign resp_valid = (fifo_cnt_r != {CNT_W{1'b0}});
    assign resp_data  = resp_valid ? fd_r[rd_ptr_r] : {xlen{1'b0}};
    assign resp_err   = resp_valid && fe_r[rd_ptr_r];

endmodule
